// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_pkg;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 4;

    // r15 is the PC; the register file never accepts a write to it
    localparam logic [ADDR_W-1:0] PC_REG = 4'd15;

    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
    } rf_wr_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO of pending long-latency register writes.
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  rf_wr_t                     din,
    input  logic                       pop,
    output rf_wr_t                     dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rf_wr_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    // A full FIFO refuses a push even when it pops in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback and a
// long-latency unit, with an in-flight scoreboard and starvation guard.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W     = rf_pkg::DATA_W,
    parameter int ADDR_W     = rf_pkg::ADDR_W,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_wa,
    input  logic [DATA_W-1:0] lu_wd,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_wa,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              dec_stall,
    output logic              wb_hold,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              wr_err
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);

    rf_wr_t            lu_entry;
    rf_wr_t            head;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              wb_pc;
    logic              head_pc;
    logic              wb_sel;
    logic              waiting;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic [SW-1:0]     starve_cnt;
    logic [SW-1:0]     starve_nxt;
    logic              hold_nxt;

    assign lu_entry.wa = lu_wa;
    assign lu_entry.wd = lu_wd;

    assign lu_ready = !full;
    assign push     = lu_valid && !full;

    rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (lu_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign wb_pc   = (wb_wa == PC_REG);
    assign head_pc = (head.wa == PC_REG);
    // Writeback cannot be stalled, so it always wins; a head aimed at r15 still drains
    assign wb_sel  = wb_we && !wb_pc;
    assign pop     = !wb_sel && !empty;

    always_comb begin
        rf_we = 1'b0;
        rf_wa = wb_wa;
        rf_wd = wb_wd;
        if (wb_sel) begin
            rf_we = 1'b1;
        end else if (pop) begin
            rf_wa = head.wa;
            rf_wd = head.wd;
            rf_we = !head_pc;
        end
        if (!rst_n) rf_we = 1'b0;
    end

    // Last term catches a second long-latency op to a register already in flight
    assign dec_stall = pending[ra1] | pending[ra2] | (issue_valid & pending[issue_wa]);

    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head.wa] = 1'b0;
        if (issue_valid && (issue_wa != PC_REG)) pending_nxt[issue_wa] = 1'b1;
    end

    // Counter saturates so a writeback that ignores wb_hold re-triggers it next cycle
    assign waiting = (count != '0) && !pop;

    always_comb begin
        starve_nxt = starve_cnt;
        if (pop)
            starve_nxt = '0;
        else if (waiting && (starve_cnt < STARVE_LIM))
            starve_nxt = starve_cnt + SW'(1);
    end

    assign hold_nxt = waiting && (starve_nxt == STARVE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            starve_cnt <= '0;
            wb_hold    <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            pending    <= pending_nxt;
            starve_cnt <= starve_nxt;
            wb_hold    <= hold_nxt;
            wr_err     <= wr_err | (wb_we && wb_pc) | (pop && head_pc);
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised and directed bench for rf_write_arbiter against a queue-based model.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int DW    = 19;
    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int SM    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_we = 1'b0;
    logic [AW-1:0] wb_wa = '0;
    logic [DW-1:0] wb_wd = '0;
    logic          lu_valid = 1'b0;
    logic          lu_ready;
    logic [AW-1:0] lu_wa = '0;
    logic [DW-1:0] lu_wd = '0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_wa = '0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] ra2 = '0;
    logic          dec_stall;
    logic          wb_hold;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          wr_err;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_we       (wb_we),
        .wb_wa       (wb_wa),
        .wb_wd       (wb_wd),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_wa       (lu_wa),
        .lu_wd       (lu_wd),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .ra1         (ra1),
        .ra2         (ra2),
        .dec_stall   (dec_stall),
        .wb_hold     (wb_hold),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .wr_err      (wr_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: queued results, in-flight registers, waiting time of the head
    rf_wr_t      q[$];
    logic [15:0] pend;
    logic        hold_m;
    logic        err_m;
    int          w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend   = '0;
        hold_m = 1'b0;
        err_m  = 1'b0;
        w      = 0;
    endtask

    task automatic idle();
        wb_we       = 1'b0;
        lu_valid    = 1'b0;
        issue_valid = 1'b0;
    endtask

    // Called shortly after a posedge with inputs already applied
    task automatic step();
        int      sz;
        logic    wb_ok, use_head, exp_we, exp_ready, exp_stall, waited;
        rf_wr_t  h, e;
        #2;
        sz        = q.size();
        exp_ready = (sz < DEPTH);
        wb_ok     = wb_we && (wb_wa != 4'd15);
        use_head  = !wb_ok && (sz > 0);
        h         = (sz > 0) ? q[0] : '0;
        exp_we    = wb_ok || (use_head && (h.wa != 4'd15));
        exp_stall = pend[ra1] | pend[ra2] | (issue_valid & pend[issue_wa]);
        chk("lu_ready", 32'(lu_ready), 32'(exp_ready));
        chk("rf_we", 32'(rf_we), 32'(exp_we));
        if (exp_we) begin
            chk("rf_wa", 32'(rf_wa), wb_ok ? 32'(wb_wa) : 32'(h.wa));
            chk("rf_wd", 32'(rf_wd), wb_ok ? 32'(wb_wd) : 32'(h.wd));
        end
        chk("dec_stall", 32'(dec_stall), 32'(exp_stall));
        chk("wb_hold", 32'(wb_hold), 32'(hold_m));
        chk("wr_err", 32'(wr_err), 32'(err_m));

        if ((wb_we && wb_wa == 4'd15) || (use_head && h.wa == 4'd15)) err_m = 1'b1;
        if (use_head) begin
            void'(q.pop_front());
            pend[h.wa] = 1'b0;
        end
        if (issue_valid && issue_wa != 4'd15) pend[issue_wa] = 1'b1;
        if (lu_valid && exp_ready) begin
            e.wa = lu_wa;
            e.wd = lu_wd;
            q.push_back(e);
        end
        waited = (sz > 0) && !use_head;
        w      = waited ? w + 1 : 0;
        hold_m = waited && (w >= SM - 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd1);
        chk("rst_dec_stall", 32'(dec_stall), 32'd0);
        chk("rst_wb_hold", 32'(wb_hold), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        rst_n = 1'b1;

        // Isolated long-latency write
        issue_valid = 1'b1; issue_wa = 4'd3; ra1 = 4'd3;
        step();
        idle();
        #1 chk("iso_stall_set", 32'(dec_stall), 32'd1);
        lu_valid = 1'b1; lu_wa = 4'd3; lu_wd = 19'h1ABCD;
        step();
        idle();
        #1;
        chk("iso_we", 32'(rf_we), 32'd1);
        chk("iso_wa", 32'(rf_wa), 32'd3);
        chk("iso_wd", 32'(rf_wd), 32'h1ABCD);
        chk("iso_stall_hold", 32'(dec_stall), 32'd1);
        step();
        #1 chk("iso_unstall", 32'(dec_stall), 32'd0);
        step();

        // Collision with writeback
        ra1 = 4'd0;
        wb_we = 1'b1; wb_wa = 4'd2; wb_wd = 19'h00222;
        lu_valid = 1'b1; lu_wa = 4'd5; lu_wd = 19'h05555;
        step();
        lu_valid = 1'b0;
        repeat (2) step();
        wb_we = 1'b0;
        #1 chk("coll_head_wa", 32'(rf_wa), 32'd5);
        step();

        // Starvation, then a writeback that ignores the hold
        wb_we = 1'b1; wb_wa = 4'd4; wb_wd = 19'h00444;
        lu_valid = 1'b1; lu_wa = 4'd6; lu_wd = 19'h06666;
        step();
        lu_valid = 1'b0;
        repeat (3) step();
        #1 chk("starve_hold", 32'(wb_hold), 32'd1);
        wb_we = 1'b0;
        step();
        #1 chk("starve_release", 32'(wb_hold), 32'd0);
        wb_we = 1'b1;
        lu_valid = 1'b1; lu_wa = 4'd1; lu_wd = 19'h01111;
        step();
        lu_valid = 1'b0;
        repeat (4) step();
        #1 chk("starve_rehold", 32'(wb_hold), 32'd1);
        wb_we = 1'b0;
        step();

        // Full FIFO: no acceptance until a pop, no loss or reordering
        wb_we = 1'b1; wb_wa = 4'd2;
        lu_valid = 1'b1; lu_wa = 4'd8; lu_wd = 19'h0AAAA;
        step();
        lu_wa = 4'd9; lu_wd = 19'h0BBBB;
        step();
        #1 chk("full_not_ready", 32'(lu_ready), 32'd0);
        lu_wa = 4'd10; lu_wd = 19'h0CCCC;
        step();
        wb_we = 1'b0;
        step();
        wb_we = 1'b1;
        step();
        idle();
        repeat (4) step();

        // r15 guard on writeback and issue
        wb_we = 1'b1; wb_wa = 4'd15; wb_wd = 19'h7FFFF;
        #1 chk("r15_we", 32'(rf_we), 32'd0);
        step();
        idle();
        #1 chk("r15_err", 32'(wr_err), 32'd1);
        issue_valid = 1'b1; issue_wa = 4'd15;
        step();
        idle();
        ra1 = 4'd15;
        #1 chk("r15_no_pend", 32'(dec_stall), 32'd0);
        step();
        ra1 = 4'd0;

        // Set and clear of the same register in one cycle
        lu_valid = 1'b1; lu_wa = 4'd7; lu_wd = 19'h07777;
        step();
        lu_valid = 1'b0;
        issue_valid = 1'b1; issue_wa = 4'd7;
        #1 chk("sc_commit_wa", 32'(rf_wa), 32'd7);
        step();
        idle();
        ra1 = 4'd7;
        #1 chk("sc_set_wins", 32'(dec_stall), 32'd1);
        step();

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            wb_we       = wb_hold ? ($urandom % 8 == 0) : ($urandom % 3 != 0);
            wb_wa       = AW'($urandom_range(0, 15));
            wb_wd       = DW'($urandom);
            lu_valid    = ($urandom % 2 == 0);
            lu_wa       = AW'($urandom_range(0, 15));
            lu_wd       = DW'($urandom);
            issue_valid = ($urandom % 4 == 0);
            issue_wa    = AW'($urandom_range(0, 15));
            ra1         = AW'($urandom_range(0, 15));
            ra2         = AW'($urandom_range(0, 15));
            step();
        end

        // Asynchronous reset with results queued and registers pending
        wb_we = 1'b1; wb_wa = 4'd2; wb_wd = 19'h00123;
        lu_valid = 1'b1; lu_wa = 4'd11; issue_valid = 1'b1; issue_wa = 4'd9;
        repeat (2) step();
        lu_valid = 1'b0; issue_valid = 1'b0; ra1 = 4'd9; ra2 = 4'd11;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_lu_ready", 32'(lu_ready), 32'd1);
        chk("arst_rf_we", 32'(rf_we), 32'd0);
        chk("arst_dec_stall", 32'(dec_stall), 32'd0);
        chk("arst_wb_hold", 32'(wb_hold), 32'd0);
        chk("arst_wr_err", 32'(wr_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle();
        for (int i = 0; i < 40; i++) begin
            wb_we    = ($urandom % 2 == 0);
            wb_wa    = AW'($urandom_range(0, 14));
            wb_wd    = DW'($urandom);
            lu_valid = ($urandom % 2 == 0);
            lu_wa    = AW'($urandom_range(0, 14));
            lu_wd    = DW'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
